// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit path.
//   tx_state_e   : transmitter FSM states
//   line_t       : bus line state as {D+, D-}
//   line_toggle  : NRZI transition between J and K
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_e;

  typedef logic [1:0] line_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [2:0] EOP_SE0_BITS = 3'd2;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  function automatic line_t line_toggle(input line_t l);
    return (l == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each USB bit period.
//   clk, n_rst : clock, synchronous active-low reset
//   clear_i    : hold the count at zero (transmitter idle)
//   bit_end_o  : high on the last clock of a bit period
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB packet transmitter: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, fed by a one-byte holding register.
//   clk, n_rst        : clock, synchronous active-low reset
//   tx_data/tx_last   : byte and end-of-packet flag, taken on tx_valid&tx_ready
//   tx_ready          : holding register empty
//   d_plus_out/d_minus_out : encoded line drive
//   transmitting      : block owns the bus
//   tx_done / tx_error: one-cycle pulses for packet complete / underrun abort
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       transmitting,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_e  state_q;
  logic       hold_full_q, hold_last_q;
  logic [7:0] hold_data_q;
  logic [7:0] shift_q;
  logic       last_q;
  logic [2:0] bit_idx_q;
  logic [2:0] ones_q;
  logic       stuff_q;
  line_t      line_q;
  logic       xmit_q, done_q, err_q;

  logic bit_end, stuff_now, byte_end, load, nxt_bit;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (state_q == IDLE),
    .bit_end_o (bit_end)
  );

  assign tx_ready     = !hold_full_q;
  assign d_plus_out   = line_q[1];
  assign d_minus_out  = line_q[0];
  assign transmitting = xmit_q;
  assign tx_done      = done_q;
  assign tx_error     = err_q;

  // A stuff slot is taken before advancing, so a byte boundary (load, EOP)
  // is only evaluated once any pending stuff bit has been sent.
  assign stuff_now = bit_end && (state_q == SYNC || state_q == DATA) &&
                     !stuff_q && (ones_q == STUFF_LIMIT);
  assign byte_end  = (bit_idx_q == 3'd7);
  assign load      = bit_end && !stuff_now && byte_end &&
                     (state_q == SYNC || (state_q == DATA && !last_q && hold_full_q));

  // Value of the bit that follows the one currently on the line.
  always_comb begin
    nxt_bit = 1'b0;
    case (state_q)
      SYNC:    nxt_bit = byte_end ? hold_data_q[0] : SYNC_PATTERN[bit_idx_q + 3'd1];
      DATA:    nxt_bit = byte_end ? hold_data_q[0] : shift_q[bit_idx_q + 3'd1];
      default: nxt_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end else if (tx_valid && !hold_full_q) begin
      hold_full_q <= 1'b1;
      hold_data_q <= tx_data;
      hold_last_q <= tx_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      ones_q    <= '0;
      stuff_q   <= 1'b0;
      line_q    <= LINE_J;
      xmit_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q    <= LINE_J;
          ones_q    <= '0;
          stuff_q   <= 1'b0;
          bit_idx_q <= '0;
          if (hold_full_q) begin
            state_q <= SYNC;
            xmit_q  <= 1'b1;
            line_q  <= SYNC_PATTERN[0] ? LINE_J : LINE_K;
            ones_q  <= SYNC_PATTERN[0] ? 3'd1 : 3'd0;
          end
        end
        SYNC, DATA: begin
          if (stuff_now) begin
            line_q  <= line_toggle(line_q);
            ones_q  <= '0;
            stuff_q <= 1'b1;
          end else if (bit_end) begin
            stuff_q <= 1'b0;
            if (!byte_end || load) begin
              line_q    <= nxt_bit ? line_q : line_toggle(line_q);
              ones_q    <= nxt_bit ? ones_q + 3'd1 : 3'd0;
              bit_idx_q <= bit_idx_q + 3'd1;
              if (load) begin
                state_q <= DATA;
                shift_q <= hold_data_q;
                last_q  <= hold_last_q;
              end
            end else begin
              state_q   <= EOP_SE0;
              line_q    <= LINE_SE0;
              bit_idx_q <= '0;
              err_q     <= !last_q;
            end
          end
        end
        EOP_SE0: begin
          if (bit_end) begin
            if (bit_idx_q == EOP_SE0_BITS - 3'd1) begin
              state_q   <= EOP_J;
              line_q    <= LINE_J;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        EOP_J: begin
          if (bit_end) begin
            state_q <= IDLE;
            xmit_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line sequences are written out by hand
// as J/K/0(SE0) characters per bit period and compared every clock.
module tb_usb_tx_encoder;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus_out, d_minus_out, transmitting, tx_done, tx_error;

  int chk_cnt = 0;
  int err_cnt = 0;
  int done_pulses = 0;
  int error_pulses = 0;
  int xmit_cycles = 0;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .d_plus_out   (d_plus_out),
    .d_minus_out  (d_minus_out),
    .transmitting (transmitting),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)      done_pulses++;
    if (tx_error)     error_pulses++;
    if (transmitting) xmit_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int unsigned n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // seq: one character per bit period, J, K or 0 (SE0); spaces ignored.
  task automatic expect_packet(input string tag, input string seq);
    int unsigned n = 0;
    int unsigned b = 0;
    bit first = 1'b1;
    logic [2:0] exp;
    while (transmitting !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " start"}, 32'(transmitting), 32'd1);
    if (transmitting !== 1'b1) return;
    for (int i = 0; i < seq.len(); i++) begin
      byte c = seq.getc(i);
      if (c == " ") continue;
      exp = (c == "J") ? 3'b110 : (c == "K") ? 3'b101 : 3'b100;
      for (int unsigned k = 0; k < CPB; k++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        check_eq($sformatf("%s bit%0d", tag, b),
                 32'({transmitting, d_plus_out, d_minus_out}), 32'(exp));
      end
      b++;
    end
    @(negedge clk);
    check_eq({tag, " end"}, 32'({transmitting, tx_done, d_plus_out, d_minus_out}), 32'b0110);
  endtask

  int d0, e0, x0, gap;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_line", 32'({d_plus_out, d_minus_out}), 32'b10);
    check_eq("rst_xmit", 32'(transmitting), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte 0xA5
    d0 = done_pulses; e0 = error_pulses; x0 = xmit_cycles;
    send_byte(8'hA5, 1'b1);
    expect_packet("t1", "KJKJKJKK KJJKJJKK 00J");
    repeat (2) @(negedge clk);
    check_eq("t1_xmit_clks", 32'(xmit_cycles - x0), 32'd76);
    check_eq("t1_done", 32'(done_pulses - d0), 32'd1);
    check_eq("t1_err", 32'(error_pulses - e0), 32'd0);

    // 2: 0xFF, stuff after six consecutive ones (SYNC's last 1 counts)
    d0 = done_pulses;
    send_byte(8'hFF, 1'b1);
    expect_packet("t2", "KJKJKJKK KKKKK J JJJ 00J");
    repeat (2) @(negedge clk);
    check_eq("t2_done", 32'(done_pulses - d0), 32'd1);

    // 3: back-to-back 0x00, 0x3F
    d0 = done_pulses;
    fork
      begin
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check_eq("t3_ready_low1", 32'(tx_ready), 32'd0);
        send_byte(8'h3F, 1'b1);
        @(negedge clk);
        check_eq("t3_ready_low2", 32'(tx_ready), 32'd0);
      end
      expect_packet("t3", "KJKJKJKK JKJKJKJK KKKKKK J KJ 00J");
    join
    repeat (2) @(negedge clk);
    check_eq("t3_done", 32'(done_pulses - d0), 32'd1);

    // 4: underrun after 0x12
    d0 = done_pulses; e0 = error_pulses;
    send_byte(8'h12, 1'b0);
    expect_packet("t4", "KJKJKJKK JJKJJKJK 00J");
    repeat (2) @(negedge clk);
    check_eq("t4_err", 32'(error_pulses - e0), 32'd1);
    check_eq("t4_done", 32'(done_pulses - d0), 32'd1);
    check_eq("t4_ready", 32'(tx_ready), 32'd1);

    // 5: reset mid-DATA, then a clean packet
    d0 = done_pulses;
    send_byte(8'h5A, 1'b1);
    gap = 0;
    while (transmitting !== 1'b1 && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    check_eq("t5_started", 32'(transmitting), 32'd1);
    repeat (40) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_line", 32'({d_plus_out, d_minus_out}), 32'b10);
    check_eq("t5_rst_xmit", 32'(transmitting), 32'd0);
    check_eq("t5_rst_ready", 32'(tx_ready), 32'd1);
    n_rst = 1'b1;
    @(negedge clk);
    check_eq("t5_no_done", 32'(done_pulses - d0), 32'd0);
    send_byte(8'hA5, 1'b1);
    expect_packet("t5", "KJKJKJKK KJJKJJKK 00J");

    // 6: next packet's byte written during EOP SE0
    repeat (2) @(negedge clk);
    d0 = done_pulses; e0 = error_pulses;
    fork
      begin
        int unsigned n = 0;
        send_byte(8'hA5, 1'b1);
        do begin
          @(negedge clk);
          n++;
        end while (!(transmitting && !d_plus_out && !d_minus_out) && n < 400);
        check_eq("t6_saw_se0", 32'({d_plus_out, d_minus_out}), 32'b00);
        send_byte(8'h00, 1'b1);
      end
      begin
        expect_packet("t6a", "KJKJKJKK KJJKJJKK 00J");
        gap = 1;
        @(negedge clk);
        while (transmitting !== 1'b1 && gap < 50) begin
          gap++;
          @(negedge clk);
        end
        check_eq("t6_gap", 32'(gap), 32'd1);
        expect_packet("t6b", "KJKJKJKK JKJKJKJK 00J");
      end
    join
    repeat (2) @(negedge clk);
    check_eq("t6_done", 32'(done_pulses - d0), 32'd2);
    check_eq("t6_err", 32'(error_pulses - e0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
